fx2_bank_stream_ctrl: RTL and testbench
=======================================

Name: fx2_bank_stream_ctrl

Overview:
- Streams completed FFT result blocks from the two external SRAM banks (bank 0 / bank 1, ping-pong) into the Cypress FX2 slave FIFO over the 16-bit fd bus.
- Arbitrates between the two banks when both hold finished blocks.
- Sequences SRAM reads and FX2 writes under FIFO full-flag back-pressure.
- Returns each bank to the FFT writer once its block has been sent.
- Sits in the ifclk domain, between the SRAM mux and the FX2 pins.

Parameters:
- AW, 16, SRAM address width.
- DW, 16, data width; equals the fd width.
- BLOCK_LEN, 4096, words per block. Must be at least 2 and no more than 2^AW.

Ports:
- ifclk  in  1  FX2 interface clock; all logic rises on this edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new block is started; a block in progress completes.
- bank_rdy  in  2  level per bank: bank holds a complete block. Held until bank_release.
- bank_release  out  2  one-cycle pulse per bank: block fully sent, bank is free.
- ram_sel  out  1  bank being read (0/1).
- ram_addr  out  AW  SRAM read address.
- ram_oe_n  out  1  SRAM output enable, active low.
- ram_d  in  DW  SRAM read data; valid one ifclk after the address (registered read).
- fd  out  DW  FX2 FIFO data.
- slwr_n  out  1  FX2 write strobe, active low.
- flag_full_n  in  1  FX2 full flag, active low. Synchronous to ifclk.
- pktend_n  out  1  FX2 packet end, active low.
- busy  out  1  high from SELECT until RELEASE.
- cur_bank  out  1  bank being served, or last served when idle.

Behaviour:
- Reset values:
  - bank_release=0, ram_sel=0, ram_addr=0, ram_oe_n=1, fd=0, slwr_n=1, pktend_n=1, busy=0.
  - cur_bank=1, so bank 0 wins the first tie.
  - FSM in IDLE; skid buffer empty; address and sent counters cleared.
- FSM states:
  - IDLE -> SELECT when enable=1 and bank_rdy is nonzero.
  - SELECT (one cycle): pick the single ready bank. If both are ready, pick the bank opposite cur_bank (round-robin). Latch it into cur_bank/ram_sel; set ram_addr=0; drive ram_oe_n=0.
  - STREAM: read and write in parallel.
    - Read side: each cycle with ram_oe_n=0 and skid occupancy + reads in flight < 2, issue a read and increment ram_addr.
    - Address stops at BLOCK_LEN-1; ram_oe_n goes 1 after the last issue.
    - Returned data enters a 2-entry skid FIFO.
  - STREAM write side:
    - slwr_n=0 in a cycle only if flag_full_n=1 in that cycle and the skid FIFO is non-empty. fd carries the head entry; the entry pops on that edge.
    - If flag_full_n=0: slwr_n=1, fd holds, reads pause.
  - STREAM exits to PKTEND when the sent counter reaches BLOCK_LEN.
  - PKTEND: see Optional Feature. -> RELEASE.
  - RELEASE: bank_release[cur_bank]=1 for one cycle; busy=0 next cycle. -> IDLE.
- Latency: first slwr_n low occurs 3 ifclk after SELECT (SELECT, addr issue, data return), provided flag_full_n=1.
- Full-rate throughput is one word per ifclk.
- The full flag may toggle every cycle. No word is lost or duplicated. Words appear strictly in address order 0..BLOCK_LEN-1.
- bank_rdy deasserting mid-block is ignored. The block completes, because the bank is owned until release.
- enable dropping mid-block does not stop the current block; no new SELECT occurs.
- reset mid-block aborts immediately to reset values. No bank_release is issued.
- Counters are AW+1 bits, so BLOCK_LEN=2^AW does not wrap.

Optional Feature:
- Macro: FX2_PKTEND_EN.
- Defined: PKTEND drives pktend_n=0 for exactly one cycle, only when flag_full_n=1. It waits in PKTEND while the FIFO is full. This commits a short final packet to the host.
- Undefined: pktend_n is tied to 1 and PKTEND lasts one cycle.

Decomposition:
- Shared package fx2_pkg holds:
  - FSM state enum (IDLE, SELECT, STREAM, PKTEND, RELEASE);
  - FX2 active-low polarity constants;
  - default DW.
- One sub-module, fx2_skid_fifo: 2-entry first-word-fall-through buffer with occupancy output. It holds the read data across full-flag stalls.

Test Plan:
- BLOCK_LEN=8, SRAM model data = address + 0x100, bank_rdy=01, flag_full_n=1 -> fd sequence 0x100..0x107 on consecutive cycles; first slwr_n low 3 cycles after SELECT; bank_release=01 pulse; with macro, a single pktend_n pulse.
- bank_rdy=11 from reset -> bank 0 served first, then bank 1. Repeat with both ready -> order alternates 0,1,0,1.
- flag_full_n low on every third cycle during a block -> exactly 8 writes, data in order, no slwr_n while full.
- flag_full_n low for 20 cycles at word 4 -> slwr_n held high; resumes with word 4; total count 8.
- Macro on, flag_full_n=0 at block end for 5 cycles -> pktend_n stays high, pulses once when the flag returns to 1.
- reset=1 at word 3 -> all outputs at reset values next cycle, no bank_release. After reset, the same bank restarts from address 0.

Source files
------------

// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - shared FSM states and FX2 pin polarity for the bank streamer
package fx2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_STREAM,
      ST_PKTEND,
      ST_RELEASE
   } fx2_state_t;

   // FX2 strobes are active low
   localparam logic FX2_ACTIVE   = 1'b0;
   localparam logic FX2_INACTIVE = 1'b1;

   localparam int FX2_DEFAULT_DW = 16;

endpackage

// File: rtl/fx2_skid_fifo.sv
// rtl/fx2_skid_fifo.sv - 2-entry first-word-fall-through buffer for SRAM read data
module fx2_skid_fifo
   import fx2_pkg::*;
#(
   parameter int DW = FX2_DEFAULT_DW
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic          o_empty,
   output logic [1:0]    o_count
);

   logic [DW-1:0] r_mem [0:1];
   logic          r_wptr;
   logic          r_rptr;
   logic [1:0]    r_count;
   logic          w_pop;

   // A pop on an empty buffer is ignored so the pointers never slip
   always_comb begin
      w_pop = i_pop && (r_count != 2'd0);
   end

   // Storage, pointers and occupancy; the caller never pushes into a full buffer
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/fx2_bank_stream_ctrl.sv
// rtl/fx2_bank_stream_ctrl.sv - streams ping-pong SRAM bank blocks into the FX2 slave FIFO (option macro: FX2_PKTEND_EN)
module fx2_bank_stream_ctrl
   import fx2_pkg::*;
#(
   parameter int AW        = 16,
   parameter int DW        = FX2_DEFAULT_DW,
   parameter int BLOCK_LEN = 4096
) (
   input  logic          i_ifclk,
   input  logic          i_reset,
   input  logic          i_enable,
   input  logic [1:0]    i_bank_rdy,
   output logic [1:0]    o_bank_release,
   output logic          o_ram_sel,
   output logic [AW-1:0] o_ram_addr,
   output logic          o_ram_oe_n,
   input  logic [DW-1:0] i_ram_d,
   output logic [DW-1:0] o_fd,
   output logic          o_slwr_n,
   input  logic          i_flag_full_n,
   output logic          o_pktend_n,
   output logic          o_busy,
   output logic          o_cur_bank
);

   // Counters carry one extra bit so a block of exactly 2^AW words does not wrap
   localparam logic [AW:0] LP_LAST = (AW+1)'(BLOCK_LEN - 1);

   fx2_state_t    r_state;
   fx2_state_t    w_next;
   logic          r_cur_bank;
   logic          r_ram_sel;
   logic          r_ram_oe_n;
   logic          r_inflight;
   logic [AW-1:0] r_ram_addr;
   logic [AW:0]   r_sent;
   logic          w_pick;
   logic          w_pop;
   logic          w_issue;
   logic          w_last_issue;
   logic          w_done;
   logic          w_empty;
   logic [1:0]    w_count;
   logic [2:0]    w_pending;

   // Bank choice: the only ready bank, or the one not served last when both are ready
   always_comb begin
      w_pick = 1'b0;
      case (i_bank_rdy)
         2'b10:   w_pick = 1'b1;
         2'b11:   w_pick = ~r_cur_bank;
         default: w_pick = 1'b0;
      endcase
   end

   // Read/write handshake; counting this cycle's pop keeps the pipe at one word per clock
   always_comb begin
      w_pop        = (r_state == ST_STREAM) && i_flag_full_n && !w_empty;
      w_pending    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_issue      = (r_state == ST_STREAM) && !r_ram_oe_n && (w_pending < 3'd2);
      w_last_issue = w_issue && ({1'b0, r_ram_addr} == LP_LAST);
      w_done       = w_pop && (r_sent == LP_LAST);
   end

   // State register
   always_ff @(posedge i_ifclk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and per-state strobes
   always_comb begin
      w_next         = r_state;
      o_bank_release = 2'b00;
      o_pktend_n     = FX2_INACTIVE;
      case (r_state)
         ST_IDLE: begin
            if (i_enable && (i_bank_rdy != 2'b00)) begin
               w_next = ST_SELECT;
            end
         end
         ST_SELECT: begin
            w_next = ST_STREAM;
         end
         ST_STREAM: begin
            if (w_done) begin
               w_next = ST_PKTEND;
            end
         end
         ST_PKTEND: begin
`ifdef FX2_PKTEND_EN
            if (i_flag_full_n) begin
               o_pktend_n = FX2_ACTIVE;
               w_next     = ST_RELEASE;
            end
`else
            w_next = ST_RELEASE;
`endif
         end
         ST_RELEASE: begin
            o_bank_release = r_cur_bank ? 2'b10 : 2'b01;
            w_next         = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // SRAM read sequencing, bank ownership and sent-word count
   always_ff @(posedge i_ifclk) begin
      if (i_reset) begin
         r_cur_bank <= 1'b1;
         r_ram_sel  <= 1'b0;
         r_ram_addr <= '0;
         r_ram_oe_n <= 1'b1;
         r_inflight <= 1'b0;
         r_sent     <= '0;
      end else begin
         r_inflight <= w_issue;
         if (r_state == ST_SELECT) begin
            r_cur_bank <= w_pick;
            r_ram_sel  <= w_pick;
            r_ram_addr <= '0;
            r_ram_oe_n <= 1'b0;
            r_sent     <= '0;
         end else begin
            if (w_last_issue) begin
               r_ram_oe_n <= 1'b1;
            end else if (w_issue) begin
               r_ram_addr <= r_ram_addr + 1'b1;
            end
            if (w_pop) begin
               r_sent <= r_sent + 1'b1;
            end
         end
      end
   end

   fx2_skid_fifo #(
      .DW(DW)
   ) u_skid (
      .i_clk   (i_ifclk),
      .i_reset (i_reset),
      .i_push  (r_inflight),
      .i_data  (i_ram_d),
      .i_pop   (w_pop),
      .o_head  (o_fd),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign o_slwr_n   = w_pop ? FX2_ACTIVE : FX2_INACTIVE;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_cur_bank = r_cur_bank;
   assign o_ram_sel  = r_ram_sel;
   assign o_ram_addr = r_ram_addr;
   assign o_ram_oe_n = r_ram_oe_n;

endmodule

// File: tb/tb_fx2_bank_stream_ctrl.sv
// tb/tb_fx2_bank_stream_ctrl.sv - self-checking bench for fx2_bank_stream_ctrl (covers FX2_PKTEND_EN when defined)
module tb_fx2_bank_stream_ctrl;

   localparam int AW = 3;
   localparam int DW = 16;
   localparam int BL = 8;

   logic          clk;
   logic          reset;
   logic          enable;
   logic          flag_full_n;
   logic [1:0]    bank_rdy;
   logic [1:0]    bank_release;
   logic          ram_sel;
   logic          ram_oe_n;
   logic          slwr_n;
   logic          pktend_n;
   logic          busy;
   logic          cur_bank;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] fd;

   fx2_bank_stream_ctrl #(.AW(AW), .DW(DW), .BLOCK_LEN(BL)) dut (
      .i_ifclk        (clk),
      .i_reset        (reset),
      .i_enable       (enable),
      .i_bank_rdy     (bank_rdy),
      .o_bank_release (bank_release),
      .o_ram_sel      (ram_sel),
      .o_ram_addr     (ram_addr),
      .o_ram_oe_n     (ram_oe_n),
      .i_ram_d        (ram_d),
      .o_fd           (fd),
      .o_slwr_n       (slwr_n),
      .i_flag_full_n  (flag_full_n),
      .o_pktend_n     (pktend_n),
      .o_busy         (busy),
      .o_cur_bank     (cur_bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [DW-1:0] wr_data[$];
   int wr_cyc[$];
   int sel_exp[$];
   int sel_act[$];
   int sel_cyc[$];
   int rel_q[$];
   int rel_cyc[$];
   int pkt_cnt, pkt_cyc, viol_cnt, mcyc, model_last;
   int fmode, fcnt, stall_at, stall_len, stall_left;
   bit prev_busy, sel_pending, stall_done, pend_rd, pend_sel;
   logic [AW-1:0] pend_addr;

   // SRAM contents: bank 0 holds addr+0x100, bank 1 holds addr+0x200
   function automatic logic [DW-1:0] word_of(input int bank, input int idx);
      return ((bank != 0) ? 16'h0200 : 16'h0100) + DW'(idx);
   endfunction

   // Reference: block k must carry word_of(sel_exp[k], 0..BL-1), consecutively
   function automatic int data_errs();
      int e = 0;
      if (wr_data.size() != sel_exp.size() * BL) e++;
      for (int k = 0; k < sel_exp.size(); k++)
         for (int i = 0; i < BL; i++)
            if (k * BL + i >= wr_data.size() || wr_data[k * BL + i] !== word_of(sel_exp[k], i)) e++;
      return e;
   endfunction

   function automatic int bank_errs();
      int e = 0;
      if (sel_act.size() != sel_exp.size()) e++;
      for (int k = 0; k < sel_exp.size() && k < sel_act.size(); k++)
         if (sel_act[k] != sel_exp[k]) e++;
      if (rel_q.size() != sel_exp.size()) e++;
      for (int k = 0; k < sel_exp.size() && k < rel_q.size(); k++)
         if (rel_q[k] != (1 << sel_exp[k])) e++;
      return e;
   endfunction

   task automatic clear_log();
      wr_data.delete(); wr_cyc.delete(); sel_exp.delete(); sel_act.delete();
      sel_cyc.delete(); rel_q.delete(); rel_cyc.delete();
      pkt_cnt = 0; pkt_cyc = 0; viol_cnt = 0;
   endtask

   // One clock: drive SRAM data and full flag after the edge, observe at the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (pend_rd) ram_d = word_of(int'(pend_sel), int'(pend_addr));
      fcnt++;
      case (fmode)
         0: flag_full_n = 1'b1;
         1: flag_full_n = (fcnt % 3) != 0;
         2: flag_full_n = ($urandom_range(0, 2) != 0);
         default: begin
            if (stall_left > 0) begin
               flag_full_n = 1'b0;
               stall_left--;
            end else if (!stall_done && wr_data.size() == stall_at) begin
               flag_full_n = 1'b0;
               stall_left = stall_len - 1;
               stall_done = 1'b1;
            end else begin
               flag_full_n = 1'b1;
            end
         end
      endcase
      @(negedge clk);
      mcyc++;
      pend_rd = !ram_oe_n;
      pend_sel = ram_sel;
      pend_addr = ram_addr;
      if (reset) begin
         prev_busy = 1'b0;
         sel_pending = 1'b0;
      end else begin
         if (sel_pending) begin
            sel_act.push_back(int'(cur_bank));
            sel_pending = 1'b0;
         end
         if (busy && !prev_busy) begin
            if (bank_rdy == 2'b11) model_last = 1 - model_last;
            else model_last = bank_rdy[1] ? 1 : 0;
            sel_exp.push_back(model_last);
            sel_cyc.push_back(mcyc);
            sel_pending = 1'b1;
         end
         prev_busy = busy;
         if (!slwr_n) begin
            wr_data.push_back(fd);
            wr_cyc.push_back(mcyc);
            if (!flag_full_n) viol_cnt++;
         end
         if (!pktend_n) begin
            pkt_cnt++;
            pkt_cyc = mcyc;
            if (!flag_full_n) viol_cnt++;
         end
         if (bank_release != 2'b00) begin
            rel_q.push_back(int'(bank_release));
            rel_cyc.push_back(mcyc);
            bank_rdy = bank_rdy & ~bank_release;
         end
      end
   endtask

   task automatic run_until_idle(input int budget, output int idle_c);
      int n = 0;
      do begin
         tick();
         n++;
      end while ((bank_rdy != 2'b00 || busy) && n < budget);
      idle_c = mcyc;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bank_rdy = 2'b00;
      tick(); tick();
      reset = 1'b0;
      model_last = 1;
      clear_log();
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; bank_rdy = 2'b00; fmode = 0;
      tick(); tick();
      total++; if (bank_release !== 2'b00) begin bad++; $display("FAIL reset_bank_release got=%b want=00", bank_release); end
      total++; if (ram_sel !== 1'b0) begin bad++; $display("FAIL reset_ram_sel got=%b want=0", ram_sel); end
      total++; if (ram_addr !== '0) begin bad++; $display("FAIL reset_ram_addr got=%0h want=0", ram_addr); end
      total++; if (ram_oe_n !== 1'b1) begin bad++; $display("FAIL reset_ram_oe_n got=%b want=1", ram_oe_n); end
      total++; if (fd !== 16'h0000) begin bad++; $display("FAIL reset_fd got=%0h want=0", fd); end
      total++; if (slwr_n !== 1'b1) begin bad++; $display("FAIL reset_slwr_n got=%b want=1", slwr_n); end
      total++; if (pktend_n !== 1'b1) begin bad++; $display("FAIL reset_pktend_n got=%b want=1", pktend_n); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (cur_bank !== 1'b1) begin bad++; $display("FAIL reset_cur_bank got=%b want=1", cur_bank); end
      reset = 1'b0;
      model_last = 1;
      clear_log();
   endtask

   task automatic test_single_block();
      int idle_c, lat, span, busy_gap, e;
      fmode = 0; enable = 1'b1; bank_rdy = 2'b01;
      run_until_idle(200, idle_c);
      tick(); tick();
      total++; if (rel_q.size() != 1 || rel_q[0] != 1) begin bad++; $display("FAIL single_release got_count=%0d want=1 pulse of 01", rel_q.size()); end
      e = data_errs();
      total++; if (e != 0) begin bad++; $display("FAIL single_data errors=%0d want=0 words=%0d", e, wr_data.size()); end
      lat = (wr_cyc.size() > 0 && sel_cyc.size() > 0) ? wr_cyc[0] - sel_cyc[0] : -1;
      total++; if (lat != 3) begin bad++; $display("FAIL single_latency got=%0d want=3", lat); end
      span = (wr_cyc.size() == BL) ? wr_cyc[BL-1] - wr_cyc[0] : -1;
      total++; if (span != BL - 1) begin bad++; $display("FAIL single_full_rate got=%0d want=%0d", span, BL - 1); end
      busy_gap = (rel_cyc.size() > 0) ? idle_c - rel_cyc[0] : -1;
      total++; if (busy_gap != 1) begin bad++; $display("FAIL single_busy_drop got=%0d want=1", busy_gap); end
      total++; if (sel_exp.size() != 1 || busy !== 1'b0) begin bad++; $display("FAIL single_no_reselect selects=%0d busy=%b want 1/0", sel_exp.size(), busy); end
`ifdef FX2_PKTEND_EN
      total++; if (pkt_cnt != 1) begin bad++; $display("FAIL single_pktend got=%0d want=1", pkt_cnt); end
`else
      total++; if (pkt_cnt != 0) begin bad++; $display("FAIL single_pktend got=%0d want=0", pkt_cnt); end
`endif
      clear_log();
   endtask

   task automatic test_round_robin();
      int idle_c, e;
      int want[4] = '{0, 1, 0, 1};
      do_reset();
      fmode = 0; enable = 1'b1; bank_rdy = 2'b11;
      run_until_idle(300, idle_c);
      bank_rdy = 2'b11;
      run_until_idle(300, idle_c);
      e = 0;
      if (sel_act.size() != 4) e++;
      for (int k = 0; k < 4 && k < sel_act.size(); k++) if (sel_act[k] != want[k]) e++;
      total++; if (e != 0) begin bad++; $display("FAIL rr_order errors=%0d blocks=%0d want order 0,1,0,1", e, sel_act.size()); end
      e = bank_errs();
      total++; if (e != 0) begin bad++; $display("FAIL rr_bank_release errors=%0d want=0", e); end
      e = data_errs();
      total++; if (e != 0) begin bad++; $display("FAIL rr_data errors=%0d want=0", e); end
      clear_log();
   endtask

   task automatic test_full_every_third();
      int idle_c, e;
      fmode = 1; enable = 1'b1; bank_rdy = 2'b01;
      run_until_idle(300, idle_c);
      total++; if (wr_data.size() != BL) begin bad++; $display("FAIL third_count got=%0d want=%0d", wr_data.size(), BL); end
      e = data_errs();
      total++; if (e != 0) begin bad++; $display("FAIL third_data errors=%0d want=0", e); end
      total++; if (viol_cnt != 0) begin bad++; $display("FAIL third_write_while_full got=%0d want=0", viol_cnt); end
      e = bank_errs();
      total++; if (e != 0) begin bad++; $display("FAIL third_release errors=%0d want=0", e); end
      clear_log();
   endtask

   task automatic test_long_stall();
      int idle_c, e, gap;
      fmode = 3; stall_at = 4; stall_len = 20; stall_left = 0; stall_done = 1'b0;
      enable = 1'b1; bank_rdy = 2'b10;
      run_until_idle(300, idle_c);
      gap = (wr_cyc.size() > 4) ? wr_cyc[4] - wr_cyc[3] : -1;
      total++; if (gap != 21) begin bad++; $display("FAIL stall_resume_gap got=%0d want=21", gap); end
      total++; if (wr_data.size() != BL) begin bad++; $display("FAIL stall_count got=%0d want=%0d", wr_data.size(), BL); end
      e = data_errs();
      total++; if (e != 0) begin bad++; $display("FAIL stall_data errors=%0d want=0", e); end
      total++; if (viol_cnt != 0) begin bad++; $display("FAIL stall_write_while_full got=%0d want=0", viol_cnt); end
      e = bank_errs();
      total++; if (e != 0) begin bad++; $display("FAIL stall_release errors=%0d want=0", e); end
      fmode = 0;
      clear_log();
   endtask

   task automatic test_enable();
      int idle_c, e;
      fmode = 0; enable = 1'b0; bank_rdy = 2'b01;
      repeat (10) tick();
      total++; if (sel_exp.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL enable_low_start selects=%0d busy=%b want 0/0", sel_exp.size(), busy); end
      enable = 1'b1;
      repeat (4) tick();
      enable = 1'b0;
      run_until_idle(200, idle_c);
      e = data_errs() + bank_errs();
      total++; if (e != 0 || rel_q.size() != 1) begin bad++; $display("FAIL enable_drop_completes errors=%0d releases=%0d want 0/1", e, rel_q.size()); end
      bank_rdy = 2'b10;
      repeat (10) tick();
      total++; if (sel_exp.size() != 1 || busy !== 1'b0) begin bad++; $display("FAIL enable_low_no_select selects=%0d busy=%b want 1/0", sel_exp.size(), busy); end
      enable = 1'b1;
      run_until_idle(200, idle_c);
      e = data_errs() + bank_errs();
      total++; if (e != 0 || rel_q.size() != 2) begin bad++; $display("FAIL enable_resume errors=%0d releases=%0d want 0/2", e, rel_q.size()); end
      clear_log();
   endtask

   task automatic test_random();
      int idle_c, e;
      fmode = 2; enable = 1'b1;
      for (int r = 0; r < 8; r++) begin
         bank_rdy = 2'($urandom_range(1, 3));
         run_until_idle(400, idle_c);
      end
      e = data_errs();
      total++; if (e != 0) begin bad++; $display("FAIL random_data errors=%0d words=%0d blocks=%0d", e, wr_data.size(), sel_exp.size()); end
      e = bank_errs();
      total++; if (e != 0) begin bad++; $display("FAIL random_arbitration errors=%0d want=0", e); end
      total++; if (viol_cnt != 0) begin bad++; $display("FAIL random_strobe_while_full got=%0d want=0", viol_cnt); end
`ifdef FX2_PKTEND_EN
      total++; if (pkt_cnt != sel_exp.size()) begin bad++; $display("FAIL random_pktend got=%0d want=%0d", pkt_cnt, sel_exp.size()); end
`else
      total++; if (pkt_cnt != 0) begin bad++; $display("FAIL random_pktend got=%0d want=0", pkt_cnt); end
`endif
      fmode = 0;
      clear_log();
   endtask

`ifdef FX2_PKTEND_EN
   task automatic test_pktend_wait();
      int idle_c, d;
      fmode = 4; stall_at = BL; stall_len = 5; stall_left = 0; stall_done = 1'b0;
      enable = 1'b1; bank_rdy = 2'b01;
      run_until_idle(300, idle_c);
      total++; if (pkt_cnt != 1) begin bad++; $display("FAIL pktend_count got=%0d want=1", pkt_cnt); end
      d = (wr_cyc.size() == BL) ? pkt_cyc - wr_cyc[BL-1] : -1;
      total++; if (d != 6) begin bad++; $display("FAIL pktend_delay got=%0d want=6", d); end
      total++; if (viol_cnt != 0) begin bad++; $display("FAIL pktend_while_full got=%0d want=0", viol_cnt); end
      fmode = 0;
      clear_log();
   endtask
`endif

   task automatic test_reset_mid_block();
      int idle_c, e, n;
      logic [26:0] obs;
      fmode = 0; enable = 1'b1; bank_rdy = 2'b01;
      n = 0;
      while (wr_data.size() < 3 && n < 50) begin
         tick();
         n++;
      end
      total++; if (wr_data.size() != 3) begin bad++; $display("FAIL midreset_reach_word3 got=%0d want=3", wr_data.size()); end
      reset = 1'b1;
      tick();
      obs = {bank_release, ram_sel, ram_addr, ram_oe_n, fd, slwr_n, pktend_n, busy, cur_bank};
      total++; if (obs !== {2'b00, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}) begin bad++; $display("FAIL midreset_outputs got=%h want=%h", obs, {2'b00, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}); end
      total++; if (rel_q.size() != 0) begin bad++; $display("FAIL midreset_no_release got=%0d want=0", rel_q.size()); end
      reset = 1'b0;
      model_last = 1;
      clear_log();
      run_until_idle(200, idle_c);
      e = data_errs() + bank_errs();
      total++; if (e != 0 || sel_act.size() != 1 || sel_act[0] != 0) begin bad++; $display("FAIL midreset_restart errors=%0d blocks=%0d want bank 0 from addr 0", e, sel_act.size()); end
      clear_log();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; bank_rdy = 2'b00; flag_full_n = 1'b1; ram_d = '0;
      fmode = 0; model_last = 1;
      test_reset();
      test_single_block();
      test_round_robin();
      test_full_every_third();
      test_long_stall();
      test_enable();
      test_random();
`ifdef FX2_PKTEND_EN
      test_pktend_wait();
`endif
      test_reset_mid_block();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
